// File: rtl/alu_serial_pkg.sv
// Shared types for the digit-serial ALU: operation codes, FSM states and
// a helper for sizing the digit counter.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_NAND = 2'b00,
        OP_NOR  = 2'b01,
        OP_ADD  = 2'b10,
        OP_SUB  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Counter width for n digits; never narrower than one bit so N=1 still works.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_serial_if.sv
// Start/busy/done request interface between the register file side (master)
// and the serial ALU (slave). Macro ALU_SERIAL_ACC_EN adds the acc_sel request bit.
interface alu_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       s_op;
`ifdef ALU_SERIAL_ACC_EN
    logic             acc_sel;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z;
    logic             cout;
    logic             zero;
    logic             ovf;

`ifdef ALU_SERIAL_ACC_EN
    modport master (output start, a, b, cin, s_op, acc_sel,
                    input  busy, done, z, cout, zero, ovf);
    modport slave  (input  start, a, b, cin, s_op, acc_sel,
                    output busy, done, z, cout, zero, ovf);
`else
    modport master (output start, a, b, cin, s_op,
                    input  busy, done, z, cout, zero, ovf);
    modport slave  (input  start, a, b, cin, s_op,
                    output busy, done, z, cout, zero, ovf);
`endif

endinterface

// File: rtl/alu_serial_digit.sv
// Combinational DIGIT-wide ALU slice: a ripple of full-adder/logic bits.
// Carry-out and carry-into-MSB are forced to 0 for the logic operations.
module alu_digit
    import alu_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    input  op_e              i_op,
    output logic [DIGIT-1:0] o_z,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic w_arith;
    logic w_carry;
    logic w_cmsb;
    logic w_bb;

    // Ripple through the slice bit by bit; SUB inverts b so a+~b+cin gives a-b.
    always_comb begin
        w_arith = (i_op == OP_ADD) || (i_op == OP_SUB);
        w_carry = i_cin;
        w_cmsb  = 1'b0;
        w_bb    = 1'b0;
        o_z     = '0;
        for (int i = 0; i < DIGIT; i++) begin
            w_bb = (i_op == OP_SUB) ? ~i_b[i] : i_b[i];
            case (i_op)
                OP_NAND: o_z[i] = ~(i_a[i] & i_b[i]);
                OP_NOR:  o_z[i] = ~(i_a[i] | i_b[i]);
                default: o_z[i] = i_a[i] ^ w_bb ^ w_carry;
            endcase
            w_cmsb  = w_carry;
            w_carry = (i_a[i] & w_bb) | (w_carry & (i_a[i] ^ w_bb));
        end
        o_cout = w_arith & w_carry;
        o_cmsb = w_arith & w_cmsb;
    end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: NAND/NOR/ADD/SUB on WIDTH-bit operands, DIGIT bits per
// clock, with start/busy/done handshake and carry/zero/overflow flags.
// Optional macro ALU_SERIAL_ACC_EN: acc_sel=1 substitutes the z register for a.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    alu_serial_if.slave bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cntWidth(N);

    state_e           r_state;
    state_e           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_z;
    logic             r_carry;
    op_e              r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_cout;
    logic             r_zero;
    logic             r_ovf;

    logic             w_busy;
    logic             w_done;
    logic             w_load;
    logic             w_last;
    logic [WIDTH-1:0] w_aIn;
    logic [DIGIT-1:0] w_digA;
    logic [DIGIT-1:0] w_digB;
    logic [DIGIT-1:0] w_digZ;
    logic             w_dcout;
    logic             w_dcmsb;
    logic [WIDTH-1:0] w_resFull;

    // A new request is accepted whenever no operation is running, including DONE.
    assign w_load = bus.start && (r_state != RUN);
    assign w_last = (r_state == RUN) && (r_cnt == CW'(N - 1));

`ifdef ALU_SERIAL_ACC_EN
    assign w_aIn = bus.acc_sel ? r_z : bus.a;
`else
    assign w_aIn = bus.a;
`endif

    // Select the current digit of the shadowed operands and merge its result.
    always_comb begin
        w_digA    = r_a[int'(r_cnt) * DIGIT +: DIGIT];
        w_digB    = r_b[int'(r_cnt) * DIGIT +: DIGIT];
        w_resFull = r_res;
        w_resFull[int'(r_cnt) * DIGIT +: DIGIT] = w_digZ;
    end

    alu_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .i_a    (w_digA),
        .i_b    (w_digB),
        .i_cin  (r_carry),
        .i_op   (r_op),
        .o_z    (w_digZ),
        .o_cout (w_dcout),
        .o_cmsb (w_dcmsb)
    );

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state: RUN for N edges, one DONE cycle, back-to-back start allowed from DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    w_next = bus.start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs decoded directly from the state.
    always_comb begin
        w_busy = (r_state == RUN);
        w_done = (r_state == DONE);
    end

    // Operand shadowing, per-digit carry chain and result/flag capture on the last digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_op    <= OP_NAND;
            r_cnt   <= '0;
            r_z     <= '0;
            r_cout  <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            r_a     <= w_aIn;
            r_b     <= bus.b;
            r_res   <= '0;
            r_carry <= bus.cin;
            r_op    <= op_e'(bus.s_op);
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_carry <= w_dcout;
            r_res   <= w_resFull;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_z    <= w_resFull;
                r_cout <= w_dcout;
                r_zero <= (w_resFull == '0);
                r_ovf  <= w_dcout ^ w_dcmsb;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.z    = r_z;
    assign bus.cout = r_cout;
    assign bus.zero = r_zero;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial: directed vector table, random operations
// against an arithmetic reference model, and hand-written multi-cycle sequences.
module tb_alu_serial;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic accSel;

    always #5 clk = ~clk;

    alu_serial_if #(.WIDTH(8)) bus1();
    alu_serial_if #(.WIDTH(8)) bus4();

    alu_serial #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    alu_serial #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] z;
        logic       cout;
        logic       zero;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    // Reference: plain integer arithmetic; overflow means the true signed result leaves -128..127.
    function automatic vec_t refModel(input logic [1:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic cin);
        vec_t r;
        int usum;
        int ssum;
        logic [7:0] bb;
        r.op = op; r.a = a; r.b = b; r.cin = cin;
        r.cout = 1'b0; r.ovf = 1'b0;
        case (op)
            2'b00: r.z = ~(a & b);
            2'b01: r.z = ~(a | b);
            default: begin
                bb     = (op == 2'b11) ? ~b : b;
                usum   = int'(a) + int'(bb) + int'(cin);
                ssum   = int'($signed(a)) + int'($signed(bb)) + int'(cin);
                r.z    = usum[7:0];
                r.cout = (usum > 255);
                r.ovf  = (ssum > 127) || (ssum < -128);
            end
        endcase
        r.zero = (r.z == 8'h00);
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkResult1(input string name, input vec_t e);
        checkOutput({name, ".z"},    int'(bus1.z),    int'(e.z));
        checkOutput({name, ".cout"}, int'(bus1.cout), int'(e.cout));
        checkOutput({name, ".zero"}, int'(bus1.zero), int'(e.zero));
        checkOutput({name, ".ovf"},  int'(bus1.ovf),  int'(e.ovf));
    endtask

    // Launch one op on the DIGIT=1 unit; returns at the negedge where done is seen (or bound hit).
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, output int lat, output int busyCycles);
        @(negedge clk);
        bus1.start = 1'b1; bus1.s_op = op; bus1.a = a; bus1.b = b; bus1.cin = cin;
`ifdef ALU_SERIAL_ACC_EN
        bus1.acc_sel = accSel;
`endif
        @(negedge clk);
        bus1.start = 1'b0;
        lat = 1;
        busyCycles = 0;
        while (!bus1.done && lat < 50) begin
            if (bus1.busy) busyCycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    // Same launch sequence for the DIGIT=4 unit.
    task automatic applyStimulus4(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, output int lat);
        @(negedge clk);
        bus4.start = 1'b1; bus4.s_op = op; bus4.a = a; bus4.b = b; bus4.cin = cin;
        @(negedge clk);
        bus4.start = 1'b0;
        lat = 1;
        while (!bus4.done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Hard stop if something wedges the whole run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int busyCycles;
        int doneCount;
        logic [7:0] zSeen;
        vec_t e;

        accSel = 1'b0;
        rst = 1'b1;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.s_op = 2'b00;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.s_op = 2'b00;
`ifdef ALU_SERIAL_ACC_EN
        bus1.acc_sel = 1'b0;
        bus4.acc_sel = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("reset.busy", int'(bus1.busy), 0);
        checkOutput("reset.done", int'(bus1.done), 0);
        checkOutput("reset.z",    int'(bus1.z),    0);
        checkOutput("reset.cout", int'(bus1.cout), 0);
        checkOutput("reset.zero", int'(bus1.zero), 0);
        checkOutput("reset.ovf",  int'(bus1.ovf),  0);
        rst = 1'b0;

        vecs[0] = '{2'b10, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{2'b11, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2'b11, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{2'b00, 8'hF0, 8'hCC, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{2'b01, 8'hF0, 8'h0C, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{2'b10, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{2'b11, 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{2'b01, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat, busyCycles);
            checkOutput($sformatf("vec%0d.latency", i), lat, 9);
            checkOutput($sformatf("vec%0d.busyCycles", i), busyCycles, 8);
            checkResult1($sformatf("vec%0d", i), vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d.donePulse", i), int'(bus1.done), 0);
            checkOutput($sformatf("vec%0d.zHeld", i), int'(bus1.z), int'(vecs[i].z));
        end

        for (int i = 0; i < 30; i++) begin
            e = refModel(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom));
            applyStimulus(e.op, e.a, e.b, e.cin, lat, busyCycles);
            checkOutput($sformatf("rand%0d.latency", i), lat, 9);
            checkResult1($sformatf("rand%0d", i), e);
        end

        // Back-to-back: a start presented during DONE launches the next op immediately.
        applyStimulus(2'b10, 8'h11, 8'h22, 1'b0, lat, busyCycles);
        checkOutput("b2b.first.z", int'(bus1.z), 8'h33);
        bus1.start = 1'b1; bus1.s_op = 2'b11; bus1.a = 8'h40; bus1.b = 8'h01; bus1.cin = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        checkOutput("b2b.busyAfterDone", int'(bus1.busy), 1);
        lat = 1;
        while (!bus1.done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("b2b.second.latency", lat, 9);
        checkOutput("b2b.second.z", int'(bus1.z), 8'h3F);

        // Operand and start changes during RUN must be ignored.
        @(negedge clk);
        bus1.start = 1'b1; bus1.s_op = 2'b10; bus1.a = 8'h10; bus1.b = 8'h20; bus1.cin = 1'b0;
        doneCount = 0;
        zSeen = 8'h00;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) bus1.start = 1'b0;
            if (c == 2) begin
                bus1.a = 8'hFF; bus1.b = 8'hFF; bus1.s_op = 2'b00; bus1.start = 1'b1;
            end
            if (c == 3) bus1.start = 1'b0;
            if (bus1.done) begin
                doneCount++;
                zSeen = bus1.z;
            end
        end
        checkOutput("runIgnore.doneCount", doneCount, 1);
        checkOutput("runIgnore.z", int'(zSeen), 8'h30);

        // Reset during the 4th RUN cycle discards the op with no done pulse.
        @(negedge clk);
        bus1.start = 1'b1; bus1.s_op = 2'b10; bus1.a = 8'h01; bus1.b = 8'h02; bus1.cin = 1'b0;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midReset.busyBefore", int'(bus1.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midReset.busy", int'(bus1.busy), 0);
        checkOutput("midReset.z", int'(bus1.z), 0);
        checkOutput("midReset.done", int'(bus1.done), 0);
        doneCount = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus1.done) doneCount++;
        end
        checkOutput("midReset.noDone", doneCount, 0);
        applyStimulus(2'b10, 8'h03, 8'h04, 1'b0, lat, busyCycles);
        checkOutput("midReset.fresh.latency", lat, 9);
        checkOutput("midReset.fresh.z", int'(bus1.z), 8'h07);

        // DIGIT=4 unit: two digits per operation, carry must cross the digit boundary.
        applyStimulus4(2'b10, 8'h7F, 8'h01, 1'b0, lat);
        checkOutput("d4.latency", lat, 3);
        checkOutput("d4.z", int'(bus4.z), 8'h80);
        checkOutput("d4.ovf", int'(bus4.ovf), 1);
        checkOutput("d4.cout", int'(bus4.cout), 0);
        for (int i = 0; i < 12; i++) begin
            e = refModel(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom));
            applyStimulus4(e.op, e.a, e.b, e.cin, lat);
            checkOutput($sformatf("d4rand%0d.latency", i), lat, 3);
            checkOutput($sformatf("d4rand%0d.z", i),    int'(bus4.z),    int'(e.z));
            checkOutput($sformatf("d4rand%0d.cout", i), int'(bus4.cout), int'(e.cout));
            checkOutput($sformatf("d4rand%0d.zero", i), int'(bus4.zero), int'(e.zero));
            checkOutput($sformatf("d4rand%0d.ovf", i),  int'(bus4.ovf),  int'(e.ovf));
        end

`ifdef ALU_SERIAL_ACC_EN
        // Accumulate chain: z starts at 0 after reset, each op adds 1 to it.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        accSel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b10, 8'h55, 8'h01, 1'b0, lat, busyCycles);
        end
        checkOutput("acc.z", int'(bus1.z), 8'h03);
        accSel = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Parametrised multi-cycle successor to the ripple-carry ALU.
- Operates on WIDTH-bit operands DIGIT bits per clock, with a start/busy/done handshake.
- Supports NAND, NOR, ADD and SUB, and produces carry, zero and signed-overflow flags.
- Sits between the register file and the writeback mux. It trades latency for a small, DIGIT-sized adder slice.

Parameters:
- WIDTH, 8, operand/result width in bits; must be at least 2 and a multiple of DIGIT.
- DIGIT, 1, bits processed per cycle. N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for ADD/SUB.
- s_op  in  2  operation: 00 NAND, 01 NOR, 10 ADD (a+b+cin), 11 SUB (a+~b+cin).
- busy  out  1  operation in progress.
- done  out  1  single-cycle completion pulse.
- z  out  WIDTH  result, held until the next completion.
- cout  out  1  carry-out; 0 for NAND/NOR.
- zero  out  1  z == 0.
- ovf  out  1  signed overflow for ADD/SUB; 0 for NAND/NOR.

Behaviour:
- Reset: when rst=1 at a rising edge, the FSM goes to IDLE and busy, done, z, cout, zero and ovf all go to 0.
  - Applies from any state, including mid-operation. The partial result is discarded and no done pulse is issued.
- FSM states:
  - IDLE: start=1 at an edge latches a, b, cin and s_op into internal shadow registers, clears the digit counter and moves to RUN. busy goes high at that edge.
  - RUN: each edge processes digit k (bits k*DIGIT .. k*DIGIT+DIGIT-1), LSB digit first. The digit's carry-out is registered and feeds the next digit. The counter increments. The edge that processes digit N-1 moves to DONE.
  - DONE: z, cout, zero and ovf are loaded at that same edge. done=1 and busy=0 for exactly one cycle, then the FSM returns to IDLE.
- Start-to-result timing: done is high in the cycle following the N-th edge after the start-sampling edge. Results and flags are valid from that cycle and stay stable until the next DONE.
- Start in DONE: start=1 while in DONE is accepted, giving back-to-back operations. The FSM goes directly to RUN, so done pulses once per operation.
- Operand stability: start and operand changes while in RUN are ignored, because the operands are shadowed.
- Arithmetic:
  - ovf = carry into the MSB XOR carry out of the MSB.
  - For SUB with cin=1 the result is a true two's-complement a-b, and cout=1 means no borrow.
- DIGIT=WIDTH: N=1, a single RUN cycle, so start-to-done latency is 2 cycles.

Optional Feature:
- Macro ALU_SERIAL_ACC_EN.
- Defined:
  - Adds an input port acc_sel (1 bit), sampled with start.
  - acc_sel=1 substitutes the current z register for operand a, enabling accumulate chains.
  - After reset z=0, so the first accumulate uses 0.
- Undefined: the acc_sel port does not exist and operand a is always the port value.

Decomposition:
- Package alu_pkg:
  - op_e enum: OP_NAND=2'b00, OP_NOR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11.
  - state_e enum: IDLE, RUN, DONE.
- Sub-module alu_digit: combinational DIGIT-wide slice.
  - Inputs: a, b, cin, op.
  - Outputs: z, cout, and carry into the slice MSB (for ovf).
  - Built as a ripple of full-adder/logic bits.
  - alu_serial instantiates it once.

Test Plan:
All scenarios use WIDTH=8, DIGIT=1 unless stated.
- ADD 0xFF+0x01, cin=0 -> z=0x00, cout=1, zero=1, ovf=0; done exactly 9 cycles after the start edge; busy high for 8 cycles.
- SUB 0x05-0x03, cin=1 -> z=0x02, cout=1, ovf=0. Then SUB 0x80-0x01, cin=1 -> z=0x7F, ovf=1.
- NAND 0xF0,0xCC -> z=0x3F, cout=0. NOR 0xF0,0x0C -> z=0x03.
- Operand changes in RUN: start ADD 0x10+0x20, then change a/b and pulse start during RUN -> result 0x30; exactly one done pulse.
- Reset mid-operation: assert rst in the 4th RUN cycle -> next cycle busy=0, z=0x00, no done pulse. A fresh start then completes normally.
- DIGIT=4: ADD 0x7F+0x01 -> z=0x80, ovf=1, done 3 cycles after the start edge. With ALU_SERIAL_ACC_EN, acc_sel=1, b=0x01 repeated three times after reset -> z=0x03.
